multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control FSM for the multicycle MIPS datapath. It decodes the 6-bit opcode and sequences the shared ALU, instruction/data memory port, register file and PC over several cycles per instruction. It drives the 2-bit `ALUOp` consumed by the ALU decoder: 00 = add, 01 = subtract, 10 = use Funct. It also generates every datapath mux select and write strobe, and stalls on a memory ready handshake.

## Interface
- No parameters; opcode encodings are fixed: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- `clk` input 1 — single clock; all state changes on rising edge.
- `reset_n` input 1 — asynchronous, active-low reset.
- `Op` input 6 — instruction opcode from the instruction register.
- `Zero` input 1 — ALU zero flag.
- `MemReady` input 1 — memory has completed the current read/write this cycle.
- `IorD` output 1 — memory address select: 0 = PC, 1 = ALUOut.
- `MemRead` / `MemWrite` output 1 each — memory access request.
- `IRWrite` output 1 — load instruction register.
- `PCEn` output 1 — PC load enable, equal to `PCWrite | (Branch & Zero)`.
- `PCSrc` output 2 — 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `ALUSrcA` output 1 — 0 = PC, 1 = register A.
- `ALUSrcB` output 2 — 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUOp` output 2 — to the ALU decoder.
- `RegDst` output 1 — 0 = rt, 1 = rd.
- `MemtoReg` output 1 — 0 = ALUOut, 1 = data register.
- `RegWrite` output 1 — register file write.
- `IllegalOp` output 1 — one-cycle pulse on an undefined opcode.

## Operation
- Moore FSM with a 4-bit state register; all outputs decode from state, except as noted below. Any output not listed for a state is 0.
- Internal `PCWrite` and `Branch` feed `PCEn`; they are not ports.
- FETCH:
  - `MemRead`=1, `ALUSrcB`=01, `ALUOp`=00.
  - `IRWrite` = `PCWrite` = `MemReady`.
  - Stay in FETCH while `MemReady`=0; go to DECODE when `MemReady`=1.
- DECODE: `ALUSrcB`=11, `ALUOp`=00 (branch target precompute). Next state by `Op`:
  - lw/sw → MEMADR
  - R-type → EXECUTE
  - beq → BRANCH
  - addi → ADDIEXEC
  - j → JUMP
  - anything else → FETCH, with `IllegalOp`=1 for this DECODE cycle.
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: `IorD`=1, `MemRead`=1. Stay until `MemReady`, then go to MEMWB.
- MEMWB: `RegDst`=0, `MemtoReg`=1, `RegWrite`=1. Go to FETCH.
- MEMWR: `IorD`=1, `MemWrite`=1. Stay until `MemReady`, then go to FETCH.
- EXECUTE: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Go to ALUWB.
- ALUWB: `RegDst`=1, `MemtoReg`=0, `RegWrite`=1. Go to FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCSrc`=01, `Branch`=1. Go to FETCH.
- ADDIEXEC: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Go to ADDIWB.
- ADDIWB: `RegDst`=0, `MemtoReg`=0, `RegWrite`=1. Go to FETCH.
- JUMP: `PCSrc`=10, `PCWrite`=1. Go to FETCH.
- Unused state encodings go to FETCH on the next edge with all strobes 0.
- `MemRead` and `MemWrite` are never asserted together. `MemWrite` and `RegWrite` are never asserted together.

## Timing
- Reset (`reset_n`=0, asynchronous): state = FETCH. While `reset_n`=0, `IRWrite`, `PCEn`, `MemRead`, `MemWrite`, `RegWrite` and `IllegalOp` are forced to 0.
- Every other output holds its FETCH value during reset: `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSrc`=00, `RegDst`=0, `MemtoReg`=0.
- Reset asserted mid-instruction aborts it immediately. No further strobes are issued. Execution restarts at FETCH on the first edge after `reset_n` rises.
- Latency with `MemReady` tied to 1:
  - j: 3 cycles
  - beq: 3 cycles
  - R-type: 4 cycles
  - addi: 4 cycles
  - sw: 4 cycles
  - lw: 5 cycles
  - illegal opcode: 2 cycles
- Each cycle with `MemReady`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. All outputs in those states are held stable during the stall.
- `MemReady` is ignored in every other state.
- `PCEn` in BRANCH follows `Zero` combinationally within the same cycle.

## Test plan
- Reset: drive `reset_n`=0 mid-EXECUTE, release → all strobes 0 during reset; on the first rising edge after release, FETCH outputs with `ALUSrcB`=01 and `ALUOp`=00.
- R-type, `MemReady`=1, `Op`=000000 → state sequence FETCH, DECODE, EXECUTE (`ALUOp`=10), ALUWB (`RegWrite`=1, `RegDst`=1), back in FETCH on cycle 5.
- lw with 2 wait cycles in MEMRD → MEMRD lasts 3 cycles with `IorD`=1; then MEMWB with `MemtoReg`=1; total 7 cycles.
- beq with `Zero`=1 → `PCEn`=1, `PCSrc`=01, `ALUOp`=01 in BRANCH; repeat with `Zero`=0 → `PCEn`=0.
- j and illegal opcode: `Op`=000010 → JUMP with `PCEn`=1, `PCSrc`=10; `Op`=111111 → `IllegalOp` pulses 1 cycle in DECODE and returns to FETCH with no writes.
- Fetch stall: hold `MemReady`=0 for 4 cycles → `IRWrite`=`PCEn`=0 throughout; both assert together in the cycle `MemReady`=1.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : Main control FSM of the multicycle MIPS datapath.
// Revision : 1.0
// ============================================================================
module multicycle_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCEn,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       IllegalOp
);

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    logic w_pc_write;
    logic w_branch;
    logic w_mem_read;
    logic w_mem_write;
    logic w_ir_write;
    logic w_reg_write;
    logic w_illegal;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    C_OP_LW, C_OP_SW: state_d = S_MEMADR;
                    C_OP_RTYPE:       state_d = S_EXECUTE;
                    C_OP_BEQ:         state_d = S_BRANCH;
                    C_OP_ADDI:        state_d = S_ADDIEXEC;
                    C_OP_J:           state_d = S_JUMP;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (Op == C_OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (MemReady) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (MemReady) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        IorD        = 1'b0;
        PCSrc       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                w_mem_read = 1'b1;
                ALUSrcB    = 2'b01;
                w_ir_write = MemReady;
                w_pc_write = MemReady;
            end
            S_DECODE: begin
                ALUSrcB   = 2'b11;
                w_illegal = !(Op inside {C_OP_RTYPE, C_OP_LW, C_OP_SW,
                                         C_OP_BEQ, C_OP_ADDI, C_OP_J});
            end
            S_MEMADR, S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD       = 1'b1;
                w_mem_read = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg    = 1'b1;
                w_reg_write = 1'b1;
            end
            S_MEMWR: begin
                IorD        = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegDst      = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSrc    = 2'b01;
                w_branch = 1'b1;
            end
            S_ADDIWB:   w_reg_write = 1'b1;
            S_JUMP: begin
                PCSrc      = 2'b10;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset parks the state in FETCH, so only the strobes need explicit gating.
    assign MemRead   = w_mem_read  & reset_n;
    assign MemWrite  = w_mem_write & reset_n;
    assign IRWrite   = w_ir_write  & reset_n;
    assign RegWrite  = w_reg_write & reset_n;
    assign IllegalOp = w_illegal   & reset_n;
    assign PCEn      = (w_pc_write | (w_branch & Zero)) & reset_n;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Scoreboard bench for the multicycle control FSM.
// Revision : 1.0
// ============================================================================
module tb_multicycle_controller;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3;
    localparam int S_MEMWB = 4, S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7;
    localparam int S_BRANCH = 8, S_ADDIEX = 9, S_ADDIWB = 10, S_JUMP = 11;
    localparam int S_RST = 12;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       IorD, MemRead, MemWrite, IRWrite, PCEn;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp;
    logic       RegDst, MemtoReg, RegWrite, IllegalOp;

    logic [15:0] obs;
    logic [15:0] expv;
    logic [15:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk(clk), .reset_n(reset_n), .Op(Op), .Zero(Zero), .MemReady(MemReady),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    assign obs = {IorD, MemRead, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA,
                  ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, IllegalOp};

    // Expected output word for a state, written straight from the state table.
    function automatic logic [15:0] ev(int st, logic rdy, logic z, logic [5:0] op);
        logic iord = 0, mrd = 0, mwr = 0, irw = 0, pcen = 0, srca = 0;
        logic regdst = 0, m2r = 0, rw = 0, ill = 0;
        logic [1:0] pcsrc = 2'b00, srcb = 2'b00, aluop = 2'b00;
        case (st)
            S_FETCH:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcen = rdy; end
            S_DECODE: begin
                srcb = 2'b11;
                ill  = !(op == OP_R || op == OP_LW || op == OP_SW ||
                         op == OP_BEQ || op == OP_ADDI || op == OP_J);
            end
            S_MEMADR: begin srca = 1; srcb = 2'b10; end
            S_MEMRD:  begin iord = 1; mrd = 1; end
            S_MEMWB:  begin m2r = 1; rw = 1; end
            S_MEMWR:  begin iord = 1; mwr = 1; end
            S_EXEC:   begin srca = 1; aluop = 2'b10; end
            S_ALUWB:  begin regdst = 1; rw = 1; end
            S_BRANCH: begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; pcen = z; end
            S_ADDIEX: begin srca = 1; srcb = 2'b10; end
            S_ADDIWB: begin rw = 1; end
            S_JUMP:   begin pcsrc = 2'b10; pcen = 1; end
            default:  begin srcb = 2'b01; end
        endcase
        return {iord, mrd, mwr, irw, pcen, pcsrc, srca, srcb, aluop,
                regdst, m2r, rw, ill};
    endfunction

    task automatic test_reset();
        int st[3] = '{S_FETCH, S_DECODE, S_EXEC};
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(ev(S_RST, 1'b0, 1'b0, OP_R));
        expv = exp_q.pop_front();
        checks++;
        if (obs !== expv) begin
            errors++; $display("FAIL reset_hold: got %h, expected %h", obs, expv);
        end
        #1 MemReady = 1'b0; reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            MemReady = 1'b1; Op = OP_R;
            exp_q.push_back(ev(st[i], MemReady, Zero, Op));
            @(negedge clk);
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL reset_pre step %0d: got %h, expected %h", i, obs, expv);
            end
            if (i < 2) begin @(posedge clk); #1; end
        end
        // Abort in the middle of EXECUTE, with MemReady high to expose ungated strobes.
        #2 reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ev(S_RST, MemReady, Zero, Op));
            #1;
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL reset_mid step %0d: got %h, expected %h", i, obs, expv);
            end
            if (i == 0) @(posedge clk);
        end
        @(negedge clk); #1 reset_n = 1'b1; MemReady = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(ev(S_FETCH, MemReady, Zero, Op));
        @(negedge clk);
        expv = exp_q.pop_front();
        checks++;
        if (obs !== expv) begin
            errors++; $display("FAIL reset_release: got %h, expected %h", obs, expv);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        int st[5] = '{S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_FETCH};
        bit rdy[5] = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            Op = OP_R; MemReady = rdy[i]; Zero = 1'b1;
            exp_q.push_back(ev(st[i], MemReady, Zero, Op));
            @(negedge clk);
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL rtype step %0d: got %h, expected %h", i, obs, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        int st[8] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB, S_FETCH};
        bit rdy[8] = '{1, 0, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            Op = OP_LW; MemReady = rdy[i]; Zero = 1'b0;
            exp_q.push_back(ev(st[i], MemReady, Zero, Op));
            @(negedge clk);
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL lw_wait step %0d: got %h, expected %h", i, obs, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw();
        int st[6] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_MEMWR, S_FETCH};
        bit rdy[6] = '{1, 0, 0, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            Op = OP_SW; MemReady = rdy[i]; Zero = 1'b0;
            exp_q.push_back(ev(st[i], MemReady, Zero, Op));
            @(negedge clk);
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL sw step %0d: got %h, expected %h", i, obs, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch(input logic z);
        int st[4] = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
        bit rdy[4] = '{1, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            Op = OP_BEQ; MemReady = rdy[i];
            Zero = (st[i] == S_BRANCH) ? z : ~z;
            exp_q.push_back(ev(st[i], MemReady, Zero, Op));
            @(negedge clk);
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL beq z=%0b step %0d: got %h, expected %h", z, i, obs, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi();
        int st[5] = '{S_FETCH, S_DECODE, S_ADDIEX, S_ADDIWB, S_FETCH};
        bit rdy[5] = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            Op = OP_ADDI; MemReady = rdy[i]; Zero = 1'b0;
            exp_q.push_back(ev(st[i], MemReady, Zero, Op));
            @(negedge clk);
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL addi step %0d: got %h, expected %h", i, obs, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int st[6] = '{S_FETCH, S_DECODE, S_JUMP, S_FETCH, S_DECODE, S_FETCH};
        bit rdy[6] = '{1, 1, 1, 1, 1, 0};
        logic [5:0] ops[6] = '{OP_J, OP_J, OP_J, OP_BAD, OP_BAD, OP_BAD};
        for (int i = 0; i < 6; i++) begin
            Op = ops[i]; MemReady = rdy[i]; Zero = 1'b0;
            exp_q.push_back(ev(st[i], MemReady, Zero, Op));
            @(negedge clk);
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL j_illegal step %0d: got %h, expected %h", i, obs, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_stall();
        int st[8] = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_JUMP, S_FETCH};
        bit rdy[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            Op = OP_J; MemReady = rdy[i]; Zero = 1'b1;
            exp_q.push_back(ev(st[i], MemReady, Zero, Op));
            @(negedge clk);
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL fetch_stall step %0d: got %h, expected %h", i, obs, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        Op       = OP_R;
        Zero     = 1'b0;
        MemReady = 1'b1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_branch(1'b1);
        test_branch(1'b0);
        test_addi();
        test_back_to_back();
        test_fetch_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
